// File: rtl/io_port_pkg.sv
// Port-bus address map and interrupt bit positions shared by the port responder.
package io_port_pkg;

   localparam logic [7:0] PID_LEDS       = 8'h40;
   localparam logic [7:0] PID_SSEG       = 8'h81;
   localparam logic [7:0] PID_SWITCHES   = 8'h20;
   localparam logic [7:0] PID_BUTTONS    = 8'h24;
   localparam logic [7:0] PID_TMR_RELOAD = 8'h30;
   localparam logic [7:0] PID_IRQ_STATUS = 8'h31;
   localparam logic [7:0] PID_IRQ_ENABLE = 8'h32;

   localparam int IRQ_TMR = 0;
   localparam int IRQ_BTN = 1;
   localparam int IRQ_W   = 2;

endpackage

// File: rtl/io_port_responder_debounce.sv
// Two-flop synchronizer plus stability counter; accepts a new vector only after it
// has been steady for CYCLES clocks and flags the bits that rose on acceptance.
module io_debounce #(
   parameter int WIDTH  = 4,
   parameter int CYCLES = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] db_o,
   output logic [WIDTH-1:0] rise_o
);

   localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

   logic [WIDTH-1:0] s1_q, s2_q, db_q, db_d, rise;
   logic [CW-1:0]    cnt_q, cnt_d;

   // s1 != s2 means the synchronized vector changes on this edge: restart the count.
   always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      rise  = '0;
      if (s1_q != s2_q) begin
         cnt_d = '0;
      end else if (s2_q != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d  = s2_q;
            cnt_d = '0;
            rise  = s2_q & ~db_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_q  <= '0;
         s2_q  <= '0;
         db_q  <= '0;
         cnt_q <= '0;
      end else begin
         s1_q  <= async_i;
         s2_q  <= s1_q;
         db_q  <= db_d;
         cnt_q <= cnt_d;
      end
   end

   assign db_o   = db_q;
   assign rise_o = rise;

endmodule

// File: rtl/io_port_responder.sv
// MCU port-bus responder: output registers, input read mux, interval timer and
// level interrupt built from sticky status bits masked by the enable register.
module io_port_responder
   import io_port_pkg::*;
#(
   parameter int PRESCALE        = 50000,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [7:0] PORT_ID,
   input  logic [7:0] OUT_PORT,
   input  logic       IO_STRB,
   output logic [7:0] IN_PORT,
   output logic       INTERRUPT,
   input  logic [7:0] SWITCHES,
   input  logic [3:0] BUTTONS,
   output logic [7:0] LEDS,
   output logic [7:0] SSEG_DATA
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [7:0]       leds_q, sseg_q, reload_q;
   logic [7:0]       sw_s1_q, sw_s2_q;
   logic [IRQ_W-1:0] status_q, status_d, enable_q, status_set, status_clr;
   logic             irq_q;
   logic [PW-1:0]    pre_q, pre_d;
   logic [7:0]       tmr_cnt_q, tmr_cnt_d;
   logic             tmr_expire;
   logic [3:0]       btn_db, btn_rise;
   logic             wr_leds, wr_sseg, wr_reload, wr_status, wr_enable;
   logic [7:0]       rd_data;

   io_debounce #(
      .WIDTH  (4),
      .CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_db (
      .clk_i   (CLK),
      .rst_n_i (RESET_N),
      .async_i (BUTTONS),
      .db_o    (btn_db),
      .rise_o  (btn_rise)
   );

   assign wr_leds   = IO_STRB && (PORT_ID == PID_LEDS);
   assign wr_sseg   = IO_STRB && (PORT_ID == PID_SSEG);
   assign wr_reload = IO_STRB && (PORT_ID == PID_TMR_RELOAD);
   assign wr_status = IO_STRB && (PORT_ID == PID_IRQ_STATUS);
   assign wr_enable = IO_STRB && (PORT_ID == PID_IRQ_ENABLE);

   // A reload write restarts the period; reload of zero parks the timer.
   always_comb begin
      pre_d      = pre_q;
      tmr_cnt_d  = tmr_cnt_q;
      tmr_expire = 1'b0;
      if (wr_reload || (reload_q == 8'd0)) begin
         pre_d     = '0;
         tmr_cnt_d = '0;
      end else if (pre_q == PRE_LAST) begin
         pre_d = '0;
         if (tmr_cnt_q == reload_q - 8'd1) begin
            tmr_cnt_d  = '0;
            tmr_expire = 1'b1;
         end else begin
            tmr_cnt_d = tmr_cnt_q + 8'd1;
         end
      end else begin
         pre_d = pre_q + 1'b1;
      end
   end

   // New events are OR-ed in after the clear so a coincident set survives W1C.
   always_comb begin
      status_set          = '0;
      status_set[IRQ_TMR] = tmr_expire;
      status_set[IRQ_BTN] = |btn_rise;
      status_clr          = wr_status ? OUT_PORT[IRQ_W-1:0] : '0;
      status_d            = (status_q & ~status_clr) | status_set;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         leds_q    <= '0;
         sseg_q    <= '0;
         reload_q  <= '0;
         enable_q  <= '0;
         status_q  <= '0;
         irq_q     <= 1'b0;
         pre_q     <= '0;
         tmr_cnt_q <= '0;
         sw_s1_q   <= '0;
         sw_s2_q   <= '0;
      end else begin
         if (wr_leds)   leds_q   <= OUT_PORT;
         if (wr_sseg)   sseg_q   <= OUT_PORT;
         if (wr_reload) reload_q <= OUT_PORT;
         if (wr_enable) enable_q <= OUT_PORT[IRQ_W-1:0];
         status_q  <= status_d;
         irq_q     <= |(status_q & enable_q);
         pre_q     <= pre_d;
         tmr_cnt_q <= tmr_cnt_d;
         sw_s1_q   <= SWITCHES;
         sw_s2_q   <= sw_s1_q;
      end
   end

   always_comb begin
      rd_data = 8'h00;
      case (PORT_ID)
         PID_LEDS:       rd_data = leds_q;
         PID_SSEG:       rd_data = sseg_q;
         PID_SWITCHES:   rd_data = sw_s2_q;
         PID_BUTTONS:    rd_data = {4'b0000, btn_db};
         PID_TMR_RELOAD: rd_data = reload_q;
         PID_IRQ_STATUS: rd_data = {6'b000000, status_q};
         PID_IRQ_ENABLE: rd_data = {6'b000000, enable_q};
         default:        rd_data = 8'h00;
      endcase
   end

   assign IN_PORT   = RESET_N ? rd_data : 8'h00;
   assign INTERRUPT = irq_q;
   assign LEDS      = leds_q;
   assign SSEG_DATA = sseg_q;

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder with a short timer prescale.
module tb_io_port_responder;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic [7:0] PORT_ID, OUT_PORT, IN_PORT, SWITCHES, LEDS, SSEG_DATA;
   logic       IO_STRB, INTERRUPT;
   logic [3:0] BUTTONS;

   int n_checks = 0;
   int n_fail   = 0;

   io_port_responder #(.PRESCALE(4), .DEBOUNCE_CYCLES(16)) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .PORT_ID   (PORT_ID),
      .OUT_PORT  (OUT_PORT),
      .IO_STRB   (IO_STRB),
      .IN_PORT   (IN_PORT),
      .INTERRUPT (INTERRUPT),
      .SWITCHES  (SWITCHES),
      .BUTTONS   (BUTTONS),
      .LEDS      (LEDS),
      .SSEG_DATA (SSEG_DATA)
   );

   always #5 CLK = ~CLK;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic do_write(input logic [7:0] id, input logic [7:0] data);
      PORT_ID  = id;
      OUT_PORT = data;
      IO_STRB  = 1'b1;
      tick(1);
      IO_STRB  = 1'b0;
   endtask

   task automatic test_reset;
      RESET_N = 1'b0; PORT_ID = 8'h40; OUT_PORT = 8'h00; IO_STRB = 1'b0;
      SWITCHES = 8'h00; BUTTONS = 4'h0;
      tick(3);
      n_checks++;
      if ({LEDS, SSEG_DATA, IN_PORT, INTERRUPT} !== 25'h0) begin
         n_fail++;
         $display("FAIL reset_outputs got leds=%h sseg=%h in=%h irq=%b want all 0",
                  LEDS, SSEG_DATA, IN_PORT, INTERRUPT);
      end
      RESET_N = 1'b1;
      tick(1);
   endtask

   task automatic test_registers;
      do_write(8'h40, 8'hA5);
      n_checks++;
      if (LEDS !== 8'hA5) begin n_fail++; $display("FAIL leds_write got %h want a5", LEDS); end
      do_write(8'h81, 8'h3C);
      n_checks++;
      if (SSEG_DATA !== 8'h3C) begin n_fail++; $display("FAIL sseg_write got %h want 3c", SSEG_DATA); end
      PORT_ID = 8'h40; #1;
      n_checks++;
      if (IN_PORT !== 8'hA5) begin n_fail++; $display("FAIL leds_read got %h want a5", IN_PORT); end
      PORT_ID = 8'h81; #1;
      n_checks++;
      if (IN_PORT !== 8'h3C) begin n_fail++; $display("FAIL sseg_read got %h want 3c", IN_PORT); end
      PORT_ID = 8'h55; #1;
      n_checks++;
      if (IN_PORT !== 8'h00) begin n_fail++; $display("FAIL unmapped_read got %h want 00", IN_PORT); end
      do_write(8'h20, 8'hFF);
      n_checks++;
      if ({LEDS, SSEG_DATA, IN_PORT} !== 24'hA53C00) begin
         n_fail++;
         $display("FAIL ro_write got leds=%h sseg=%h sw=%h want a5 3c 00", LEDS, SSEG_DATA, IN_PORT);
      end
      PORT_ID = 8'h40; OUT_PORT = 8'h11; IO_STRB = 1'b0;
      tick(1);
      n_checks++;
      if (LEDS !== 8'hA5) begin n_fail++; $display("FAIL no_strobe got %h want a5", LEDS); end
      do_write(8'h32, 8'hFF);
      PORT_ID = 8'h32; #1;
      n_checks++;
      if (IN_PORT !== 8'h03) begin n_fail++; $display("FAIL enable_read got %h want 03", IN_PORT); end
      do_write(8'h32, 8'h00);
   endtask

   task automatic test_switches;
      SWITCHES = 8'h5A; PORT_ID = 8'h20; #1;
      n_checks++;
      if (IN_PORT !== 8'h00) begin n_fail++; $display("FAIL sw_cycle0 got %h want 00", IN_PORT); end
      tick(1);
      n_checks++;
      if (IN_PORT !== 8'h00) begin n_fail++; $display("FAIL sw_cycle1 got %h want 00", IN_PORT); end
      tick(1);
      n_checks++;
      if (IN_PORT !== 8'h5A) begin n_fail++; $display("FAIL sw_cycle2 got %h want 5a", IN_PORT); end
   endtask

   task automatic test_buttons;
      logic [7:0] st, bt;
      for (int i = 0; i < 8; i++) begin
         BUTTONS[2] = ~BUTTONS[2];
         tick(5);
      end
      BUTTONS[2] = 1'b1;
      tick(17);
      PORT_ID = 8'h31; #1; st = IN_PORT;
      PORT_ID = 8'h24; #1; bt = IN_PORT;
      n_checks++;
      if ({st, bt} !== 16'h0000) begin
         n_fail++; $display("FAIL btn_early got status=%h btn=%h want 00 00", st, bt);
      end
      tick(1);
      PORT_ID = 8'h31; #1; st = IN_PORT;
      PORT_ID = 8'h24; #1; bt = IN_PORT;
      n_checks++;
      if ({st, bt} !== 16'h0204) begin
         n_fail++; $display("FAIL btn_press got status=%h btn=%h want 02 04", st, bt);
      end
      do_write(8'h31, 8'h02);
      BUTTONS[2] = 1'b0;
      tick(30);
      PORT_ID = 8'h31; #1; st = IN_PORT;
      PORT_ID = 8'h24; #1; bt = IN_PORT;
      n_checks++;
      if ({st, bt} !== 16'h0000) begin
         n_fail++; $display("FAIL btn_release got status=%h btn=%h want 00 00", st, bt);
      end
   endtask

   // Expiry lands 12 clocks after the reload write edge with PRESCALE=4, reload=3.
   task automatic test_timer;
      do_write(8'h32, 8'h01);
      do_write(8'h30, 8'h03);
      PORT_ID = 8'h30; #1;
      n_checks++;
      if (IN_PORT !== 8'h03) begin n_fail++; $display("FAIL reload_read got %h want 03", IN_PORT); end
      PORT_ID = 8'h31;
      tick(11);
      n_checks++;
      if (IN_PORT !== 8'h00) begin n_fail++; $display("FAIL tmr_before got %h want 00", IN_PORT); end
      tick(1);
      n_checks++;
      if ({IN_PORT, INTERRUPT} !== {8'h01, 1'b0}) begin
         n_fail++; $display("FAIL tmr_expire got status=%h irq=%b want 01 0", IN_PORT, INTERRUPT);
      end
      tick(1);
      n_checks++;
      if (INTERRUPT !== 1'b1) begin n_fail++; $display("FAIL tmr_irq got %b want 1", INTERRUPT); end
      do_write(8'h31, 8'h01);
      n_checks++;
      if ({IN_PORT, INTERRUPT} !== {8'h00, 1'b1}) begin
         n_fail++; $display("FAIL w1c_first got status=%h irq=%b want 00 1", IN_PORT, INTERRUPT);
      end
      tick(1);
      n_checks++;
      if (INTERRUPT !== 1'b0) begin n_fail++; $display("FAIL w1c_irq_low got %b want 0", INTERRUPT); end
      tick(8);
      n_checks++;
      if (IN_PORT !== 8'h00) begin n_fail++; $display("FAIL refire_early got %h want 00", IN_PORT); end
      tick(1);
      n_checks++;
      if (IN_PORT !== 8'h01) begin n_fail++; $display("FAIL refire got %h want 01", IN_PORT); end
      tick(11);
      do_write(8'h31, 8'h01);
      n_checks++;
      if (IN_PORT !== 8'h01) begin n_fail++; $display("FAIL set_beats_w1c got %h want 01", IN_PORT); end
      tick(1);
      n_checks++;
      if (INTERRUPT !== 1'b1) begin n_fail++; $display("FAIL irq_before_disable got %b want 1", INTERRUPT); end
      do_write(8'h32, 8'h00);
      tick(1);
      PORT_ID = 8'h31; #1;
      n_checks++;
      if ({IN_PORT, INTERRUPT} !== {8'h01, 1'b0}) begin
         n_fail++; $display("FAIL disable got status=%h irq=%b want 01 0", IN_PORT, INTERRUPT);
      end
   endtask

   task automatic test_async_reset;
      do_write(8'h32, 8'h01);
      tick(1);
      n_checks++;
      if (INTERRUPT !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq got %b want 1", INTERRUPT); end
      #2 RESET_N = 1'b0;
      PORT_ID = 8'h40;
      #1;
      n_checks++;
      if ({LEDS, SSEG_DATA, IN_PORT, INTERRUPT} !== 25'h0) begin
         n_fail++;
         $display("FAIL async_reset got leds=%h sseg=%h in=%h irq=%b want all 0",
                  LEDS, SSEG_DATA, IN_PORT, INTERRUPT);
      end
      tick(2);
      RESET_N = 1'b1;
      do_write(8'h32, 8'h01);
      PORT_ID = 8'h31;
      tick(20);
      n_checks++;
      if ({IN_PORT, INTERRUPT} !== {8'h00, 1'b0}) begin
         n_fail++; $display("FAIL timer_parked got status=%h irq=%b want 00 0", IN_PORT, INTERRUPT);
      end
      do_write(8'h30, 8'h03);
      PORT_ID = 8'h31;
      tick(11);
      n_checks++;
      if (IN_PORT !== 8'h00) begin n_fail++; $display("FAIL restart_early got %h want 00", IN_PORT); end
      tick(1);
      n_checks++;
      if (IN_PORT !== 8'h01) begin n_fail++; $display("FAIL restart_expire got %h want 01", IN_PORT); end
   endtask

   initial begin
      test_reset();
      test_registers();
      test_switches();
      test_buttons();
      test_timer();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
